apu_pulse_reg_writer: RTL
=========================

Name: apu_pulse_reg_writer

Overview:
Register-write front end for one pulse channel. It consumes the byte stream from the serial receiver, parses two-byte address/data frames, and maintains the four channel registers reg_4000..reg_4003. It emits the one-cycle reg_event strobe that the pulse generator uses to reload its length counter, envelope, sweep and sequencer state. One instance sits between the UART byte receiver and each pulse generator.

Parameters:
BASE_ADDR, 8'h00, register offset of this channel's reg_4000 in the frame address space; bits [1:0] must be 0
TIMEOUT_CYCLES, 16'd50000, maximum clk cycles allowed between an address byte and its data byte before the frame is abandoned

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
byte_valid  input  1  one-cycle strobe; byte_data is valid this cycle
byte_data  input  8  received byte
reg_4000  output  8  duty / length-halt / decay-halt / volume register
reg_4001  output  8  sweep register
reg_4002  output  8  timer low byte
reg_4003  output  8  length select / timer high bits
reg_event  output  1  one-cycle pulse on every write to reg_4003
frame_error  output  1  one-cycle pulse on a malformed or timed-out frame

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-low, rst_n.
- Reset: all four registers 8'h00, reg_event 0, frame_error 0, FSM in IDLE, timeout counter 0. Reset mid-frame discards the frame and produces no write.
- Frame format: address byte, then data byte. Address 8'hFF is a sync byte. Other addresses with bit7=1 are illegal. Addresses 8'h00..8'h7F are legal.
- There is no input backpressure. byte_valid is accepted in every cycle and every state.
- FSM states:
  - IDLE:
    - byte 8'hFF: stay in IDLE, no error.
    - bit7=1, not 8'hFF: pulse frame_error, stay in IDLE.
    - bit7=0: latch addr, clear timeout counter, go to DATA.
  - DATA:
    - The timeout counter increments each cycle without byte_valid.
    - When the counter reaches TIMEOUT_CYCLES-1 with no byte: pulse frame_error, go to IDLE.
    - On byte_valid, any value including 8'hFF is data. If addr[7:2]==BASE_ADDR[7:2], write byte_data into register addr[1:0]. Go to IDLE (or CHECK when the optional feature is enabled).
- Write latency: the data byte accepted in cycle N appears on reg_40xx in cycle N+1.
- reg_event: asserted in cycle N+1, the same cycle reg_4003 shows the new value, so the pulse generator samples the new value on that edge.
  - Writes to offsets 0..2 never assert reg_event.
  - Rewriting reg_4003 with an identical value still asserts reg_event.
- Frames addressed to another channel are consumed silently: no write, no event, no error.
- Back-to-back frames with no idle cycles are supported. Consecutive reg_4003 writes two bytes apart produce two separate one-cycle reg_event pulses.
- The timeout counter width is $clog2(TIMEOUT_CYCLES). It saturates and does not wrap.

Optional Feature:
APU_FRAME_CHECKSUM_EN
- Defined:
  - Each frame is three bytes: address, data, checksum. A valid checksum equals address XOR data XOR 8'hA5.
  - The data byte is held in a staging register and the FSM enters CHECK, which uses the same timeout rule as DATA.
  - On a match, commit the write; latency is counted from the checksum byte, and reg_event follows the same rule.
  - On a mismatch, pulse frame_error with no write.
  - Frames to other channels are still fully consumed, including the checksum.
- Undefined: two-byte frames; the CHECK state and staging register are absent.

Decomposition:
- Shared package apu_pkg holds:
  - address constants: SYNC_BYTE=8'hFF, CHECKSUM_SALT=8'hA5, offsets REG_OFS_4000..REG_OFS_4003 = 0..3
  - FSM state typedef: IDLE, DATA, CHECK
  - DEFAULT_TIMEOUT_CYCLES
- Natural sub-module: apu_frame_timeout. It is the saturating timeout counter with clear and enable inputs and an expired output, reused by the triangle and noise writers.

Test Plan:
- Reset, then bytes 8'h03, 8'h5C with BASE_ADDR=0 -> reg_4003=8'h5C in cycle N+1, reg_event high exactly 1 cycle in that cycle, other registers 8'h00.
- Bytes 8'h00, 8'hBF then 8'h02, 8'hFD -> reg_4000=8'hBF, reg_4002=8'hFD, reg_event never asserted, frame_error never asserted.
- BASE_ADDR=8'h04, frame 8'h01, 8'h88 -> no register change, no event, no error; a following frame 8'h05, 8'h88 sets reg_4001=8'h88.
- Address 8'h02, then TIMEOUT_CYCLES idle cycles, then 8'h77 -> frame_error pulse; 8'h77 is parsed as an address, so the next byte 8'h11 writes nothing.
- Byte 8'h90 in IDLE -> frame_error pulse; 8'hFF in IDLE -> no error; frame 8'h01, 8'hFF -> reg_4001=8'hFF.
- rst_n low for 1 cycle between address 8'h03 and data 8'h12 -> no write, no event, registers 8'h00; 8'h12 is parsed as an address.
- With APU_FRAME_CHECKSUM_EN defined:
  - Frame 8'h03, 8'h5C, 8'hFA -> write and reg_event.
  - Checksum 8'hFB -> frame_error, reg_4003 unchanged.

Source files
------------

// File: rtl/apu_pkg.sv
// Shared constants and FSM state type for the APU channel register writers.
package apu_pkg;

  localparam logic [7:0]  SYNC_BYTE              = 8'hFF;
  localparam logic [7:0]  CHECKSUM_SALT          = 8'hA5;
  localparam logic [1:0]  REG_OFS_4000           = 2'd0;
  localparam logic [1:0]  REG_OFS_4001           = 2'd1;
  localparam logic [1:0]  REG_OFS_4002           = 2'd2;
  localparam logic [1:0]  REG_OFS_4003           = 2'd3;
  localparam logic [15:0] DEFAULT_TIMEOUT_CYCLES = 16'd50000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    CHECK = 2'd2
  } apu_state_e;

endpackage

// File: rtl/apu_frame_timeout.sv
// Saturating inter-byte timeout counter; expired is high while the count sits at TIMEOUT_CYCLES-1.
module apu_frame_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clear)
      cnt_d = '0;
    else if (enable && (cnt_q != LIMIT))
      cnt_d = cnt_q + CNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/apu_pulse_reg_writer.sv
// Pulse-channel register writer: parses address/data byte frames into reg_4000..reg_4003.
// Define APU_FRAME_CHECKSUM_EN for three-byte frames with an XOR checksum.
module apu_pulse_reg_writer
  import apu_pkg::*;
#(
  parameter logic [7:0]  BASE_ADDR      = 8'h00,
  parameter logic [15:0] TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic [7:0] reg_4000,
  output logic [7:0] reg_4001,
  output logic [7:0] reg_4002,
  output logic [7:0] reg_4003,
  output logic       reg_event,
  output logic       frame_error
);

  apu_state_e       state_q, state_d;
  logic [7:0]       addr_q, addr_d;
  logic [3:0][7:0]  regs_q, regs_d;
  logic             event_q, event_d;
  logic             error_q, error_d;
  logic             commit;
  logic [7:0]       wr_data;
  logic             to_clear, to_enable, to_expired;
`ifdef APU_FRAME_CHECKSUM_EN
  logic [7:0]       stage_q, stage_d;
`endif

  // Any accepted byte restarts the inter-byte window; it only runs mid-frame.
  assign to_clear  = (state_q == IDLE) || byte_valid;
  assign to_enable = (state_q != IDLE) && !byte_valid;

  apu_frame_timeout #(
    .TIMEOUT_CYCLES (int'(TIMEOUT_CYCLES))
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (to_clear),
    .enable  (to_enable),
    .expired (to_expired)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    regs_d  = regs_q;
    event_d = 1'b0;
    error_d = 1'b0;
    commit  = 1'b0;
    wr_data = byte_data;
`ifdef APU_FRAME_CHECKSUM_EN
    stage_d = stage_q;
`endif
    case (state_q)
      IDLE: begin
        if (byte_valid && (byte_data != SYNC_BYTE)) begin
          if (byte_data[7]) begin
            error_d = 1'b1;
          end else begin
            addr_d  = byte_data;
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (byte_valid) begin
`ifdef APU_FRAME_CHECKSUM_EN
          stage_d = byte_data;
          state_d = CHECK;
`else
          commit  = 1'b1;
          state_d = IDLE;
`endif
        end else if (to_expired) begin
          error_d = 1'b1;
          state_d = IDLE;
        end
      end
`ifdef APU_FRAME_CHECKSUM_EN
      CHECK: begin
        if (byte_valid) begin
          state_d = IDLE;
          if (byte_data == (addr_q ^ stage_q ^ CHECKSUM_SALT)) begin
            commit  = 1'b1;
            wr_data = stage_q;
          end else begin
            error_d = 1'b1;
          end
        end else if (to_expired) begin
          error_d = 1'b1;
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    // Frames for other channels are consumed without effect.
    if (commit && (addr_q[7:2] == BASE_ADDR[7:2])) begin
      regs_d[addr_q[1:0]] = wr_data;
      event_d             = (addr_q[1:0] == REG_OFS_4003);
    end
  end

  // NOTE: the four registers are architectural state the pulse generator reads, so they are reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      regs_q  <= '0;
      event_q <= 1'b0;
      error_q <= 1'b0;
`ifdef APU_FRAME_CHECKSUM_EN
      stage_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      regs_q  <= regs_d;
      event_q <= event_d;
      error_q <= error_d;
`ifdef APU_FRAME_CHECKSUM_EN
      stage_q <= stage_d;
`endif
    end
  end

  assign reg_4000    = regs_q[REG_OFS_4000];
  assign reg_4001    = regs_q[REG_OFS_4001];
  assign reg_4002    = regs_q[REG_OFS_4002];
  assign reg_4003    = regs_q[REG_OFS_4003];
  assign reg_event   = event_q;
  assign frame_error = error_q;

endmodule
